// File: rtl/fetch_queue_unit.sv
// Decoupled fetch stage: in-order imem requests, credit-reserved instruction queue, redirect flush.
// Optional misaligned-redirect fault entry is enabled by defining TARTARUGA_FETCH_MISALIGN_EN.
module fetch_queue_unit #(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      fetch_pc, fetch_pc_next;
    logic [31:0]      resp_pc, resp_pc_next;
    logic [OUT_W-1:0] outstanding, outstanding_next;
    logic [OUT_W-1:0] drop_cnt, drop_cnt_next;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [31:0]      q_instr [QUEUE_DEPTH];
    logic [31:0]      q_pc    [QUEUE_DEPTH];

    logic             empty, req_fire, rsp_keep, push, pop;
    logic [31:0]      target_pc;
    logic             halted, fault_pend;
    logic [31:0]      fault_pc;
    logic [31:0]      push_instr, push_pc;

`ifdef TARTARUGA_FETCH_MISALIGN_EN
    logic                   misaligned;
    logic [QUEUE_DEPTH-1:0] q_fault;

    assign target_pc  = redirect_pc_i;
    assign misaligned = |redirect_pc_i[1:0];

    // A misaligned target halts fetch and queues a single fault entry the following cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            halted     <= 1'b0;
            fault_pend <= 1'b0;
            fault_pc   <= '0;
        end else if (redirect_i) begin
            halted     <= misaligned;
            fault_pend <= misaligned;
            fault_pc   <= redirect_pc_i;
        end else begin
            fault_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_fault[wr_ptr] <= fault_pend;
        end
    end

    assign fault_o = ~empty & q_fault[rd_ptr];
`else
    logic unused_target_lsb;

    assign target_pc         = {redirect_pc_i[31:2], 2'b00};
    assign unused_target_lsb = ^redirect_pc_i[1:0];
    assign halted            = 1'b0;
    assign fault_pend        = 1'b0;
    assign fault_pc          = '0;
    assign fault_o           = 1'b0;
`endif

    assign empty = (count == '0);

    // Credit rule: every accepted request already owns a queue slot.
    assign imem_req_valid_o = rstn_i & ~redirect_i & ~halted
                            & (32'(outstanding) < MAX_OUTSTANDING)
                            & ((32'(outstanding) + 32'(count)) < QUEUE_DEPTH);
    assign imem_req_addr_o  = fetch_pc;
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;

    assign rsp_keep   = imem_rsp_valid_i & ~redirect_i & (drop_cnt == '0);
    assign push       = ~redirect_i & (fault_pend | rsp_keep);
    assign push_instr = fault_pend ? NOP : imem_rsp_data_i;
    assign push_pc    = fault_pend ? fault_pc : resp_pc;

    assign instr_valid_o = ~empty & ~redirect_i;
    assign pop           = instr_valid_o & instr_ready_i;
    assign instr_o       = empty ? '0 : q_instr[rd_ptr];
    assign pc_o          = empty ? '0 : q_pc[rd_ptr];

    always_comb begin
        fetch_pc_next    = fetch_pc;
        resp_pc_next     = resp_pc;
        drop_cnt_next    = drop_cnt;
        outstanding_next = outstanding + OUT_W'(req_fire) - OUT_W'(imem_rsp_valid_i);
        if (redirect_i) begin
            fetch_pc_next = target_pc;
            resp_pc_next  = target_pc;
            // Every response still in flight belongs to the abandoned stream.
            drop_cnt_next = outstanding - OUT_W'(imem_rsp_valid_i);
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc + 32'd4;
            end
            if (imem_rsp_valid_i) begin
                if (drop_cnt != '0) begin
                    drop_cnt_next = drop_cnt - OUT_W'(1);
                end else begin
                    resp_pc_next = resp_pc + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            fetch_pc    <= fetch_pc_next;
            resp_pc     <= resp_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_instr[wr_ptr] <= push_instr;
            q_pc[wr_ptr]    <= push_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a variable-latency in-order imem model.
// Misaligned-fault steps follow TARTARUGA_FETCH_MISALIGN_EN.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rstn, redirect, req_ready, instr_ready;
    logic [31:0] redirect_pc;
    logic        req_valid, rsp_valid, instr_valid, fault;
    logic [31:0] req_addr, rsp_data, instr, pc;

    int unsigned lat;
    logic [3:0]  slot_v;
    logic [31:0] slot_a [4];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc, base_pc;

    always #5 clk = ~clk;

    fetch_queue_unit dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_o          (instr),
        .pc_o             (pc),
        .fault_o          (fault)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // imem: a request accepted at an edge is answered exactly lat cycles later
    assign rsp_valid = slot_v[0];
    assign rsp_data  = mem_data(slot_a[0]);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_v <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                slot_v[i] <= slot_v[i+1];
                slot_a[i] <= slot_a[i+1];
            end
            slot_v[3] <= 1'b0;
            if (req_valid && req_ready) begin
                slot_v[lat-1] <= 1'b1;
                slot_a[lat-1] <= req_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!instr_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_arrives"}, 32'(instr_valid), 32'd1);
    endtask

    task automatic quiesce(input int unsigned new_lat);
        req_ready   = 1'b0;
        instr_ready = 1'b1;
        repeat (6) @(negedge clk);
        lat = new_lat;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; redirect = 1'b0; redirect_pc = '0;
        req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
        repeat (2) @(negedge clk);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_addr", req_addr, 32'h8000_0000);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // Test 1: L=1 streaming, first valid two cycles after release
        rstn = 1'b1;
        @(negedge clk);
        check("t1_cycle1_empty", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_valid", 32'(instr_valid), 32'd1);
            check("t1_pc", pc, 32'h8000_0000 + 32'(4 * i));
            check("t1_instr", instr, mem_data(32'h8000_0000 + 32'(4 * i)));
        end

        // Test 2: decode stall fills the queue, then drains in order
        instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("t2_full_no_req", 32'(req_valid), 32'd0);
        check("t2_full_valid", 32'(instr_valid), 32'd1);
        check("t2_head_held", pc, 32'h8000_0008);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("t2_drain_valid", 32'(instr_valid), 32'd1);
            check("t2_drain_pc", pc, 32'h8000_0008 + 32'(4 * i));
            check("t2_drain_instr", instr, mem_data(32'h8000_0008 + 32'(4 * i)));
        end

        // Test 3: L=3, two outstanding, redirect drops both
        quiesce(3);
        check("t3_idle", 32'(instr_valid), 32'd0);
        req_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_out_limit", 32'(req_valid), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h8000_0100;
        #1;
        check("t3_redir_no_req", 32'(req_valid), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("t3", 16);
        check("t3_pc", pc, 32'h8000_0100);
        check("t3_instr", instr, mem_data(32'h8000_0100));
        @(negedge clk);
        wait_valid("t3b", 8);
        check("t3_pc_next", pc, 32'h8000_0104);

        // Back-to-back redirects: last target wins
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h8000_0300;
        @(negedge clk);
        redirect_pc = 32'h8000_0380;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("t3c", 16);
        check("t3_b2b_pc", pc, 32'h8000_0380);

        // Test 4: redirect with rsp_valid and a popping head in the same cycle
        quiesce(1);
        req_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_pre_valid", 32'(instr_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h8000_0400;
        #1;
        check("t4_redir_valid", 32'(instr_valid), 32'd0);
        check("t4_redir_req", 32'(req_valid), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        check("t4_flushed", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("t4_still_empty", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("t4_new_valid", 32'(instr_valid), 32'd1);
        check("t4_new_pc", pc, 32'h8000_0400);

        // Address wrap 0xFFFF_FFFC -> 0
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("wrap", 8);
        check("wrap_pc0", pc, 32'hFFFF_FFF8);
        @(negedge clk);
        check("wrap_pc1", pc, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_pc2", pc, 32'h0000_0000);
        check("wrap_instr2", instr, mem_data(32'h0000_0000));

`ifdef TARTARUGA_FETCH_MISALIGN_EN
        // Test 6: misaligned redirect yields one fault entry and halts fetch
        redirect = 1'b1; redirect_pc = 32'h8000_0102;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("t6", 8);
        check("t6_fault", 32'(fault), 32'd1);
        check("t6_pc", pc, 32'h8000_0102);
        check("t6_instr", instr, 32'h0000_0013);
        check("t6_halt_req", 32'(req_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("t6_single_entry", 32'(instr_valid), 32'd0);
        check("t6_still_halted", 32'(req_valid), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h8000_0200;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("t6b", 8);
        check("t6_resume_pc", pc, 32'h8000_0200);
        check("t6_resume_fault", 32'(fault), 32'd0);
`else
        // Low target bits are ignored without the fault feature
        redirect = 1'b1; redirect_pc = 32'h8000_0202;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("lsb", 8);
        check("lsb_forced_pc", pc, 32'h8000_0200);
        check("lsb_no_fault", 32'(fault), 32'd0);
`endif

        // Test 5: random ready on both sides, L = 1..4
        for (int l = 1; l <= 4; l++) begin
            quiesce(l);
            base_pc  = 32'h8000_0000 + 32'(l * 32'h1000);
            exp_pc   = base_pc;
            redirect = 1'b1; redirect_pc = base_pc;
            @(negedge clk);
            redirect = 1'b0;
            repeat (150) begin
                req_ready   = 1'($urandom_range(0, 1));
                instr_ready = 1'($urandom_range(0, 1));
                #1;
                if (instr_valid && instr_ready) begin
                    check("t5_pc_seq", pc, exp_pc);
                    check("t5_instr", instr, mem_data(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end
                @(negedge clk);
            end
            check("t5_progress", 32'((exp_pc - base_pc) >= 32'd40), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
